oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter TRIGGER_ADDR, default 16'h4014, CPU write address that starts a transfer.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, destination address of every DMA write.
REQ-003 clk4  input  1  system clock; all state changes on rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 cyc  input  1  one-clk4 pulse marking the end of one CPU bus cycle and the start of the next.
REQ-006 cpu_addr  input  16  CPU address of the ending cycle.
REQ-007 cpu_rw  input  1  CPU direction of the ending cycle; 1 = read.
REQ-008 cpu_dout  input  8  CPU write data of the ending cycle.
REQ-009 din  input  8  shared-bus read data of the ending cycle.
REQ-010 rdy  output  1  CPU ready; 0 = CPU held.
REQ-011 dma_active  output  1  1 = bus mux selects addr/dout/rw from this block.
REQ-012 addr  output  16  DMA bus address.
REQ-013 dout  output  8  DMA write data.
REQ-014 rw  output  1  DMA bus direction; 1 = read.
REQ-015 done  output  1  one-clk4 pulse at transfer completion.

Function
REQ-016 The block SHALL update state and registered outputs only on clk4 edges with cyc=1, except done, which SHALL clear on the next clk4 edge.
REQ-017 The block SHALL keep a parity flag put, toggled on every cyc edge; put=0 marks a get cycle and put=1 a put cycle for the cycle starting.
REQ-018 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-019 IDLE: on a cyc edge with cpu_rw=0 and cpu_addr=TRIGGER_ADDR, latch page<=cpu_dout, cnt<=0, rdy<=0, go HALT; any other access SHALL be ignored.
REQ-020 HALT: dma_active=0; on a cyc edge with cpu_rw=0, remain HALT; with cpu_rw=1, go READ if the starting cycle is get, else ALIGN.
REQ-021 ALIGN: one dummy cycle, dma_active=0, then READ.
REQ-022 READ: dma_active=1, addr={page,cnt}, rw=1; at its ending cyc edge latch din into an 8-bit buffer and go WRITE.
REQ-023 WRITE: dma_active=1, addr=OAM_DATA_ADDR, rw=0, dout=buffer; at its ending cyc edge cnt<=cnt+1 (8-bit).
REQ-024 At the end of WRITE with cnt=8'hFF, go IDLE with rdy<=1, dma_active<=0, rw<=1, and pulse done.
REQ-025 Otherwise WRITE SHALL go READ; READ SHALL always fall on get cycles and WRITE on put cycles.
REQ-026 Source addresses SHALL stay within the page; {page,8'hFF} SHALL be followed by no carry into page.
REQ-027 rdy SHALL be 0 continuously from HALT entry through the final WRITE.
REQ-028 With the CPU reading immediately, rdy SHALL stay low for exactly 513 cycles without ALIGN and 514 with ALIGN.
REQ-029 Trigger writes are impossible while rdy=0 and SHALL NOT be decoded outside IDLE.
REQ-030 clk4 edges with cyc=0 SHALL leave all state unchanged.

Reset
REQ-031 While n_reset=0: state=IDLE, rdy=1, dma_active=0, addr=16'h0000, dout=8'h00, rw=1, done=0, put=0, cnt=0, page=0, buffer=0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no further bus writes; the next trigger SHALL restart at byte 0.

Verification
REQ-033 Reset: hold n_reset low, toggle clk4/cyc -> all outputs at REQ-031 values, no done.
REQ-034 Even alignment: RAM 0x0200-0x02FF = i^8'hA5; write 8'h02 to 16'h4014 so HALT ends before a get cycle; CPU reads -> no ALIGN, 256 writes to 16'h2004 with data i^8'hA5 in order, rdy low 513 cycles, one done pulse.
REQ-035 Odd alignment: same as REQ-034 with trigger shifted one cycle -> one ALIGN cycle, rdy low 514 cycles, identical data.
REQ-036 Halt extension: after trigger CPU performs 2 more writes (cpu_rw=0) -> HALT lasts 3 cycles, rdy low 515 or 516 cycles, data unchanged.
REQ-037 Page 8'hFF: last read addr 16'hFFFF, no access to 16'h0000; byte 100 aborted by reset -> rdy=1 at once, retrigger restarts at {page,8'h00}.
REQ-038 Non-triggers: write to 16'h4015 and read of 16'h4014 -> rdy stays 1, dma_active stays 0.

Source files
------------

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: halts the CPU and copies one 256-byte page to the OAM data port.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk4,
  input  logic        n_reset,
  input  logic        cyc,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  din,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        rw,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state, state_nxt;
  logic        put;
  logic [7:0]  page, page_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  buffer, buffer_nxt;
  logic        rdy_nxt, active_nxt, rw_nxt, done_nxt;
  logic [15:0] addr_nxt;

  // The read buffer doubles as the write data driven during WRITE.
  assign dout = buffer;

  always_ff @(posedge clk4 or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      put        <= 1'b0;
      page       <= 8'h00;
      cnt        <= 8'h00;
      buffer     <= 8'h00;
      rdy        <= 1'b1;
      dma_active <= 1'b0;
      addr       <= 16'h0000;
      rw         <= 1'b1;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cyc) begin
        state      <= state_nxt;
        put        <= ~put;
        page       <= page_nxt;
        cnt        <= cnt_nxt;
        buffer     <= buffer_nxt;
        rdy        <= rdy_nxt;
        dma_active <= active_nxt;
        addr       <= addr_nxt;
        rw         <= rw_nxt;
        done       <= done_nxt;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    page_nxt   = page;
    cnt_nxt    = cnt;
    buffer_nxt = buffer;
    rdy_nxt    = rdy;
    active_nxt = dma_active;
    addr_nxt   = addr;
    rw_nxt     = rw;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!cpu_rw && cpu_addr == TRIGGER_ADDR) begin
          page_nxt  = cpu_dout;
          cnt_nxt   = 8'h00;
          rdy_nxt   = 1'b0;
          state_nxt = HALT;
        end
      end
      HALT: begin
        // CPU writes run to completion; the halt takes hold on its first read.
        if (cpu_rw) begin
          if (put) begin
            state_nxt  = READ;
            active_nxt = 1'b1;
            addr_nxt   = {page, cnt};
            rw_nxt     = 1'b1;
          end else begin
            state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        state_nxt  = READ;
        active_nxt = 1'b1;
        addr_nxt   = {page, cnt};
        rw_nxt     = 1'b1;
      end
      READ: begin
        buffer_nxt = din;
        state_nxt  = WRITE;
        addr_nxt   = OAM_DATA_ADDR;
        rw_nxt     = 1'b0;
      end
      WRITE: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == 8'hFF) begin
          state_nxt  = IDLE;
          rdy_nxt    = 1'b1;
          active_nxt = 1'b0;
          rw_nxt     = 1'b1;
          done_nxt   = 1'b1;
        end else begin
          // Low byte wraps inside the page; the page never increments.
          state_nxt = READ;
          addr_nxt  = {page, cnt_nxt};
          rw_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - randomized bus-level bench for oam_dma against a page-copy reference model.
module tb_oam_dma;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;

  logic        clk4 = 1'b0;
  logic        n_reset = 1'b0;
  logic        cyc = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  din = 8'h00;
  logic        rdy, dma_active, rw, done;
  logic [15:0] addr;
  logic [7:0]  dout;

  oam_dma #(.TRIGGER_ADDR(TRIG), .OAM_DATA_ADDR(OAM)) dut (
    .clk4(clk4), .n_reset(n_reset), .cyc(cyc), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout), .din(din), .rdy(rdy), .dma_active(dma_active), .addr(addr),
    .dout(dout), .rw(rw), .done(done)
  );

  always #5 clk4 = ~clk4;

  int checks = 0;
  int errors = 0;
  int edges = 0;
  int rdy_low = 0;
  int done_cnt = 0;
  int par_bad = 0;
  int gap_bad = 0;
  logic [7:0]  ram [0:65535];
  logic [15:0] rd_q [$];
  logic [23:0] wr_q [$];

  always @(negedge clk4) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One CPU bus cycle: log what the bus shows, then end the cycle with a cyc edge.
  task automatic cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
    logic [26:0] snap;
    int gap;
    if (!rdy) rdy_low++;
    if (dma_active && rw) begin
      rd_q.push_back(addr);
      if (edges % 2 != 0) par_bad++;
    end
    if (dma_active && !rw) begin
      wr_q.push_back({addr, dout});
      if (edges % 2 != 1) par_bad++;
    end
    din = ram[(dma_active && rw) ? addr : a];
    cpu_addr = a; cpu_rw = r; cpu_dout = d; cyc = 1'b1;
    @(posedge clk4); #1;
    cyc = 1'b0;
    edges++;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      cpu_addr = TRIG; cpu_rw = 1'b0; cpu_dout = 8'($urandom); din = 8'($urandom);
      snap = {rdy, dma_active, addr, dout, rw};
      @(posedge clk4); #1;
      if ({rdy, dma_active, addr, dout, rw} !== snap || done) gap_bad++;
    end
  endtask

  task automatic idle_read();
    cycle(16'($urandom_range(16'h0000, 16'h3FFF)), 1'b1, 8'h00);
  endtask

  task automatic pad_to(input int par);
    while (edges % 2 != par) idle_read();
  endtask

  task automatic xfer(input logic [7:0] pg, input int nwr, input int abort_at);
    int tidx, align;
    logic fin;
    rd_q.delete(); wr_q.delete();
    rdy_low = 0; done_cnt = 0; par_bad = 0;
    cycle(TRIG, 1'b0, pg);
    tidx = edges;
    repeat (nwr) cycle(16'($urandom_range(16'h0000, 16'h1FFF)), 1'b0, 8'($urandom));
    align = (tidx + nwr + 1) % 2;
    fin = 1'b0;
    for (int k = 0; k < 700 && !fin; k++) begin
      cycle(16'($urandom_range(16'h8000, 16'hFFFF)), 1'b1, 8'h00);
      if (abort_at >= 0 && wr_q.size() == abort_at && dma_active && rw) begin
        #2 n_reset = 1'b0;
        #1;
        chk("abort_rdy", rdy, 1);
        chk("abort_act", dma_active, 0);
        chk("abort_rw", rw, 1);
        return;
      end
      if (rdy) fin = 1'b1;
    end
    chk("xfer_end", fin, 1);
    idle_read();
    chk("rdy_low", rdy_low, 513 + nwr + align);
    chk("n_rd", rd_q.size(), 256);
    chk("n_wr", wr_q.size(), 256);
    for (int i = 0; i < 256; i++) begin
      if (i < rd_q.size()) chk("rd_addr", rd_q[i], {pg, 8'(i)});
      if (i < wr_q.size()) begin
        chk("wr_addr", wr_q[i][23:8], OAM);
        chk("wr_data", wr_q[i][7:0], ram[{pg, 8'(i)}]);
      end
    end
    chk("parity", par_bad, 0);
    chk("done_pulses", done_cnt, 1);
    chk("idle_act", dma_active, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;

    // Reset held: triggers ignored, outputs at reset values.
    done_cnt = 0;
    repeat (3) begin
      cycle(TRIG, 1'b0, 8'h02);
      chk("rst_rdy", rdy, 1);
      chk("rst_act", dma_active, 0);
      chk("rst_addr", addr, 16'h0000);
      chk("rst_dout", dout, 8'h00);
      chk("rst_rw", rw, 1);
      chk("rst_done", done, 0);
    end
    chk("rst_done_cnt", done_cnt, 0);
    n_reset = 1'b1;
    edges = 0;

    // Non-trigger accesses.
    cycle(16'h4015, 1'b0, 8'h02);
    cycle(TRIG, 1'b1, 8'h02);
    cycle(16'h4013, 1'b0, 8'h02);
    idle_read();
    chk("nt_rdy", rdy, 1);
    chk("nt_act", dma_active, 0);

    pad_to(0);
    xfer(8'h02, 0, -1);
    pad_to(1);
    xfer(8'h02, 0, -1);
    idle_read();
    xfer(8'h02, 2, -1);
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(0, 3)) idle_read();
      xfer(8'($urandom), $urandom_range(0, 3), -1);
    end

    // Page FF with reset mid-transfer, then a full retrigger.
    repeat ($urandom_range(0, 3)) idle_read();
    done_cnt = 0;
    xfer(8'hFF, $urandom_range(0, 1), 100);
    repeat (2) idle_read();
    chk("abort_nowr", wr_q.size(), 100);
    chk("abort_done", done_cnt, 0);
    n_reset = 1'b1;
    edges = 0;
    idle_read();
    xfer(8'hFF, 0, -1);
    if (rd_q.size() == 256) begin
      chk("ff_first", rd_q[0], 16'hFF00);
      chk("ff_last", rd_q[255], 16'hFFFF);
    end else begin
      chk("ff_size", rd_q.size(), 256);
    end

    chk("cyc0_hold", gap_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
